// File: rtl/cache_fill_ctrl.sv
// Direct-mapped read-only byte cache with a single outstanding line fill. Hit latency is 2 cycles from accept; a miss responds 2 cycles after fill_ready.
// One request in flight, and req_ready is high only in IDLE. Optional saturating hit/miss counters are built when CACHE_FILL_PERF_COUNT_EN is defined.
module cache_fill_ctrl #(
    parameter int  BLOCK_SIZE_BYTE = 16,
    parameter int  CACHE_SIZE_BYTE = 32 * 1024,
    localparam int SET   = CACHE_SIZE_BYTE / BLOCK_SIZE_BYTE,
    localparam int OFF_W = $clog2(BLOCK_SIZE_BYTE),
    localparam int IDX_W = $clog2(SET),
    localparam int TAG_W = 16 - IDX_W - OFF_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req_valid,
    input  logic [15:0]                  req_addr,
    output logic                         req_ready,
    output logic                         resp_valid,
    output logic [7:0]                   resp_data,
    output logic                         resp_hit,
    output logic                         fill_start,
    output logic [TAG_W-1:0]             fill_tag,
    output logic [IDX_W-1:0]             fill_index,
    output logic [OFF_W-1:0]             fill_offset,
    input  logic [BLOCK_SIZE_BYTE*8-1:0] fill_block,
    input  logic                         fill_ready,
    output logic [31:0]                  hit_count,
    output logic [31:0]                  miss_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_FILL_WAIT,
        S_UPDATE,
        S_RESPOND
    } state_t;

    state_t                       r_state;
    state_t                       w_state_nxt;

    logic [SET-1:0]               r_valid;
    logic [TAG_W-1:0]             r_tag_mem  [SET];
    logic [BLOCK_SIZE_BYTE*8-1:0] r_data_mem [SET];
    logic [BLOCK_SIZE_BYTE*8-1:0] r_fill_line;

    logic [TAG_W-1:0]             r_tag;
    logic [IDX_W-1:0]             r_idx;
    logic [OFF_W-1:0]             r_off;
    logic [7:0]                   r_pend_data;
    logic                         r_pend_hit;
    logic                         r_resp_valid;
    logic [7:0]                   r_resp_data;
    logic                         r_resp_hit;
    logic                         r_fill_start;

    logic [BLOCK_SIZE_BYTE*8-1:0] w_line;
    logic                         w_hit;

    assign w_line = r_data_mem[r_idx];
    assign w_hit  = r_valid[r_idx] && (r_tag_mem[r_idx] == r_tag);

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:      if (req_valid) w_state_nxt = S_LOOKUP;
            S_LOOKUP:    w_state_nxt = w_hit ? S_RESPOND : S_FILL_WAIT;
            S_FILL_WAIT: if (fill_ready) w_state_nxt = S_UPDATE;
            S_UPDATE:    w_state_nxt = S_RESPOND;
            S_RESPOND:   w_state_nxt = S_IDLE;
            default:     w_state_nxt = S_IDLE;
        endcase
    end

    // Response fields are staged in r_pend_* and published together with resp_valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid      <= '0;
            r_tag        <= '0;
            r_idx        <= '0;
            r_off        <= '0;
            r_pend_data  <= '0;
            r_pend_hit   <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_resp_hit   <= 1'b0;
            r_fill_start <= 1'b0;
        end else begin
            r_resp_valid <= (r_state == S_RESPOND);
            r_fill_start <= (r_state == S_LOOKUP) && !w_hit;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_tag <= req_addr[15 -: TAG_W];
                        r_idx <= req_addr[OFF_W +: IDX_W];
                        r_off <= req_addr[OFF_W-1:0];
                    end
                end
                S_LOOKUP: begin
                    if (w_hit) begin
                        r_pend_data <= w_line[{r_off, 3'b000} +: 8];
                        r_pend_hit  <= 1'b1;
                    end
                end
                S_UPDATE: begin
                    r_valid[r_idx] <= 1'b1;
                    r_pend_data    <= r_fill_line[{r_off, 3'b000} +: 8];
                    r_pend_hit     <= 1'b0;
                end
                S_RESPOND: begin
                    r_resp_data <= r_pend_data;
                    r_resp_hit  <= r_pend_hit;
                end
                default: ;
            endcase
        end
    end

    // Line storage is not reset; valid bits alone decide whether contents count.
    always_ff @(posedge clk) begin
        if (rst_n && r_state == S_FILL_WAIT && fill_ready) begin
            r_fill_line <= fill_block;
        end
        if (rst_n && r_state == S_UPDATE) begin
            r_data_mem[r_idx] <= r_fill_line;
            r_tag_mem[r_idx]  <= r_tag;
        end
    end

    assign req_ready   = (r_state == S_IDLE);
    assign resp_valid  = r_resp_valid;
    assign resp_data   = r_resp_data;
    assign resp_hit    = r_resp_hit;
    assign fill_start  = r_fill_start;
    assign fill_tag    = r_tag;
    assign fill_index  = r_idx;
    assign fill_offset = r_off;

`ifdef CACHE_FILL_PERF_COUNT_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (r_state == S_LOOKUP) begin
            if (w_hit) begin
                if (r_hit_cnt != 32'hFFFF_FFFF) r_hit_cnt <= r_hit_cnt + 32'd1;
            end else begin
                if (r_miss_cnt != 32'hFFFF_FFFF) r_miss_cnt <= r_miss_cnt + 32'd1;
            end
        end
    end

    assign hit_count  = r_hit_cnt;
    assign miss_count = r_miss_cnt;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Directed bench for cache_fill_ctrl: fills, hits, conflict eviction, request held during a fill, reset during a fill.
module tb_cache_fill_ctrl;

`ifdef CACHE_FILL_PERF_COUNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_valid;
    logic [15:0]  req_addr;
    logic         req_ready;
    logic         resp_valid;
    logic [7:0]   resp_data;
    logic         resp_hit;
    logic         fill_start;
    logic [0:0]   fill_tag;
    logic [10:0]  fill_index;
    logic [3:0]   fill_offset;
    logic [127:0] fill_block;
    logic         fill_ready;
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;

    int errors = 0;
    int checks = 0;
    int m_hits = 0;
    int m_miss = 0;

    cache_fill_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_hit(resp_hit),
        .fill_start(fill_start), .fill_tag(fill_tag), .fill_index(fill_index),
        .fill_offset(fill_offset), .fill_block(fill_block), .fill_ready(fill_ready),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] mk_line(input logic [7:0] base);
        logic [127:0] l;
        for (int i = 0; i < 16; i++) l[i*8 +: 8] = base + 8'(i);
        return l;
    endfunction

    // One complete request; for a miss the line is supplied as bytes base..base+15 after dly cycles.
    task automatic run_req(input logic [15:0] addr, input logic exp_hit, input logic [7:0] exp_data,
                           input logic [7:0] base, input int dly, input logic hold_other);
        @(negedge clk);
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_addr  = addr;
        @(negedge clk);
        req_valid = 1'b0;
        chk("req_ready_busy", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("fill_start", 32'(fill_start), 32'(!exp_hit));
        if (exp_hit) begin
            m_hits++;
            chk("resp_early", 32'(resp_valid), 32'd0);
        end else begin
            m_miss++;
            chk("fill_tag", 32'(fill_tag), 32'(addr[15]));
            chk("fill_index", 32'(fill_index), 32'(addr[14:4]));
            chk("fill_offset", 32'(fill_offset), 32'(addr[3:0]));
            if (hold_other) begin
                req_valid = 1'b1;
                req_addr  = addr ^ 16'h5A5A;
            end
            for (int i = 0; i < dly; i++) begin
                @(negedge clk);
                chk("fill_start_once", 32'(fill_start), 32'd0);
                chk("resp_in_fill", 32'(resp_valid), 32'd0);
                if (hold_other) chk("req_ready_fill", 32'(req_ready), 32'd0);
            end
            req_valid  = 1'b0;
            fill_ready = 1'b1;
            fill_block = mk_line(base);
            @(negedge clk);
            fill_ready = 1'b0;
            fill_block = '0;
            chk("resp_update", 32'(resp_valid), 32'd0);
            @(negedge clk);
            chk("resp_early", 32'(resp_valid), 32'd0);
        end
        @(negedge clk);
        chk("resp_valid", 32'(resp_valid), 32'd1);
        chk("resp_data", 32'(resp_data), 32'(exp_data));
        chk("resp_hit", 32'(resp_hit), 32'(exp_hit));
        chk("req_ready_resp", 32'(req_ready), 32'd1);
        chk("hit_count", hit_count, PERF ? 32'(m_hits) : 32'd0);
        chk("miss_count", miss_count, PERF ? 32'(m_miss) : 32'd0);
        @(negedge clk);
        chk("resp_pulse", 32'(resp_valid), 32'd0);
        chk("resp_hold", 32'(resp_data), 32'(exp_data));
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_addr   = '0;
        fill_block = '0;
        fill_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_data", 32'(resp_data), 32'd0);
        chk("rst_fill_start", 32'(fill_start), 32'd0);
        chk("rst_fill_index", 32'(fill_index), 32'd0);
        chk("rst_hit_count", hit_count, 32'd0);
        rst_n = 1'b1;

        run_req(16'h0123, 1'b0, 8'h03, 8'h00, 5, 1'b0);
        run_req(16'h012A, 1'b1, 8'h0A, 8'h00, 0, 1'b0);
        run_req(16'h8123, 1'b0, 8'h83, 8'h80, 2, 1'b0);
        run_req(16'h0123, 1'b0, 8'h43, 8'h40, 3, 1'b1);
        run_req(16'h012A, 1'b1, 8'h4A, 8'h00, 0, 1'b0);

        // Reset while a fill is outstanding, then a late fill_ready.
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 16'h0456;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("rf_fill_start", 32'(fill_start), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n  = 1'b1;
        m_hits = 0;
        m_miss = 0;
        chk("rf_req_ready", 32'(req_ready), 32'd1);
        chk("rf_fill_index", 32'(fill_index), 32'd0);
        chk("rf_fill_offset", 32'(fill_offset), 32'd0);
        chk("rf_miss_count", miss_count, 32'd0);
        fill_ready = 1'b1;
        fill_block = mk_line(8'hC0);
        @(negedge clk);
        fill_ready = 1'b0;
        fill_block = '0;
        for (int i = 0; i < 4; i++) begin
            chk("rf_no_resp", 32'(resp_valid), 32'd0);
            @(negedge clk);
        end
        run_req(16'h0456, 1'b0, 8'hE6, 8'hE0, 1, 1'b0);
        run_req(16'h012A, 1'b0, 8'h2A, 8'h20, 1, 1'b0);
        run_req(16'h0455, 1'b1, 8'hE5, 8'h00, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cache_fill_ctrl.md
CACHE_FILL_CTRL -- requirements
Module: cache_fill_ctrl

Interface
REQ-001 SHALL provide parameter BLOCK_SIZE_BYTE, default 16, line size in bytes (power of 2).
REQ-002 SHALL provide parameter CACHE_SIZE_BYTE, default 32*1024, direct-mapped capacity in bytes; SET = CACHE_SIZE_BYTE/BLOCK_SIZE_BYTE, OFF_W = log2(BLOCK_SIZE_BYTE), IDX_W = log2(SET), TAG_W = 16-IDX_W-OFF_W.
REQ-003 SHALL have ports:
  clk  in  1  single clock, all logic on rising edge.
  rst_n  in  1  synchronous, active-low reset.
  req_valid  in  1  CPU byte-read request.
  req_addr  in  16  byte address {tag,index,offset}.
  req_ready  out  1  block can accept a request.
  resp_valid  out  1  one-cycle response strobe.
  resp_data  out  8  requested byte.
  resp_hit  out  1  1 = hit, 0 = serviced by fill.
  fill_start  out  1  one-cycle pulse to downstream block fetcher.
  fill_tag  out  TAG_W  tag of missing line, held stable while fill outstanding.
  fill_index  out  IDX_W  index of missing line, held stable.
  fill_offset  out  OFF_W  offset of missing byte, held stable.
  fill_block  in  BLOCK_SIZE_BYTE*8  fetched line, byte 0 in bits [7:0].
  fill_ready  in  1  fill_block valid this cycle.
  hit_count  out  32  hit counter (see Configuration).
  miss_count  out  32  miss counter (see Configuration).

Function
REQ-004 SHALL hold per-set valid bit, tag array and data array (SET x BLOCK_SIZE_BYTE*8).
REQ-005 SHALL implement states IDLE, LOOKUP, FILL_WAIT, UPDATE, RESPOND; one-hot or binary encoding free.
REQ-006 IDLE: req_ready=1; on req_valid=1 SHALL capture req_addr and go to LOOKUP; otherwise stay.
REQ-007 req_ready SHALL be 0 in every state other than IDLE; req_valid outside IDLE SHALL be ignored (no capture, no count).
REQ-008 LOOKUP: hit = valid[index] && tag[index]==captured tag; hit SHALL go to RESPOND with resp_hit=1 and resp_data = byte [offset] of the stored line.
REQ-009 LOOKUP miss SHALL assert fill_start for exactly one cycle (the cycle after LOOKUP) with fill_tag/fill_index/fill_offset valid, and go to FILL_WAIT.
REQ-010 FILL_WAIT: SHALL wait unbounded for fill_ready=1, then register fill_block and go to UPDATE; fill_ready outside FILL_WAIT SHALL be ignored.
REQ-011 UPDATE: SHALL write line, tag, set valid[index]=1, go to RESPOND with resp_hit=0 and resp_data = byte [offset] of fill_block.
REQ-012 RESPOND: resp_valid=1 for exactly one cycle, then IDLE; resp_data/resp_hit SHALL hold until next response.
REQ-013 Hit latency: resp_valid SHALL rise 2 cycles after the accepting edge; miss latency: resp_valid SHALL rise 2 cycles after the edge sampling fill_ready=1.
REQ-014 A miss to a valid set SHALL overwrite it (no write-back; read-only cache).
REQ-015 Back-to-back: a request present in IDLE immediately after RESPOND SHALL be accepted that cycle; a subsequent hit on a just-filled line SHALL return the filled byte.

Reset
REQ-016 rst_n=0 at a rising edge SHALL force IDLE, clear all valid bits, req_ready=1 after release, resp_valid=0, resp_data=0, resp_hit=0, fill_start=0, fill_tag/index/offset=0, counters=0; data/tag arrays not reset.
REQ-017 Reset during FILL_WAIT SHALL abandon the fill without updating any line; a late fill_ready SHALL be ignored.

Configuration
REQ-018 Macro CACHE_FILL_PERF_COUNT_EN defined: hit_count increments on each LOOKUP hit, miss_count on each LOOKUP miss, both saturating at 32'hFFFF_FFFF.
REQ-019 Macro undefined: counters SHALL not be built; hit_count and miss_count SHALL be tied to 0.

Verification
REQ-020 Reset, then req_addr=16'h0123 -> fill_start pulse, fill_index=11'h012, fill_offset=4'h3; fill_block bytes 0x00..0x0F after 5 cycles -> resp_valid, resp_data=8'h03, resp_hit=0, miss_count=1.
REQ-021 After REQ-020, req_addr=16'h012A -> resp_valid 2 cycles after accept, resp_data=8'h0A, resp_hit=1, no fill_start, hit_count=1.
REQ-022 Conflict: req_addr=16'h8123 (same index, tag 1) -> miss and refill; then 16'h0123 -> miss again (line evicted).
REQ-023 req_valid held high during FILL_WAIT with differing address -> req_ready=0, no second fill_start, address ignored until IDLE.
REQ-024 rst_n=0 in FILL_WAIT, fill_ready pulsed after release -> no resp_valid; next request to same address misses.
REQ-025 With CACHE_FILL_PERF_COUNT_EN undefined, REQ-020/021 sequence -> hit_count=miss_count=0, functional responses unchanged.
